// File: rtl/checker_memory_arbiter.sv
// Two-master Wishbone arbiter for the checker memory slave port: round-robin grant held for a
// whole cycle, plus a stall watchdog that returns err to the owning master.
module checker_memory_arbiter #(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  input  logic        m0_we_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  input  logic        m1_we_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  output logic [3:0]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  output logic        s_we_o,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  localparam bit WdogEn = (TIMEOUT != 0);
  localparam logic [TIMEOUT_W-1:0] WdogLast = TIMEOUT_W'(WdogEn ? TIMEOUT - 1 : 0);

  state_e               state_q, state_d;
  logic                 last_owner_q, last_owner_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;

  logic        owned;
  logic        fire;
  logic [31:0] mst_adr;
  logic [31:0] mst_dat;
  logic [3:0]  mst_sel;
  logic        mst_stb;
  logic        mst_cyc;
  logic        mst_we;

  assign owned   = (state_q != StIdle);
  assign grant_o = {state_q == StOwn1, state_q == StOwn0};
  assign busy_o  = owned;

  // Read data is broadcast; only the owner's ack qualifies it.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  always_comb begin
    mst_adr = m0_adr_i;
    mst_dat = m0_dat_i;
    mst_sel = m0_sel_i;
    mst_stb = m0_stb_i;
    mst_cyc = m0_cyc_i;
    mst_we  = m0_we_i;
    if (state_q == StOwn1) begin
      mst_adr = m1_adr_i;
      mst_dat = m1_dat_i;
      mst_sel = m1_sel_i;
      mst_stb = m1_stb_i;
      mst_cyc = m1_cyc_i;
      mst_we  = m1_we_i;
    end
  end

  // An ack landing on the last watchdog count wins over the timeout.
  assign fire = WdogEn && owned && mst_stb && !s_ack_i && (wdog_q == WdogLast);

  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    if (owned) begin
      s_adr_o = mst_adr;
      s_dat_o = mst_dat;
      s_sel_o = mst_sel;
      s_we_o  = mst_we;
      s_stb_o = mst_stb & ~fire;
      s_cyc_o = mst_cyc & ~fire;
    end
    m0_ack_o = (state_q == StOwn0) & s_ack_i;
    m1_ack_o = (state_q == StOwn1) & s_ack_i;
    m0_err_o = (state_q == StOwn0) & fire;
    m1_err_o = (state_q == StOwn1) & fire;
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      StIdle: begin
        if (m0_cyc_i && (!m1_cyc_i || last_owner_q)) begin
          state_d      = StOwn0;
          last_owner_d = 1'b0;
        end else if (m1_cyc_i) begin
          state_d      = StOwn1;
          last_owner_d = 1'b1;
        end
      end
      StOwn0: if (!m0_cyc_i || fire) state_d = StIdle;
      StOwn1: if (!m1_cyc_i || fire) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    wdog_d = (!owned || !mst_stb || s_ack_i || fire) ? '0 : wdog_q + TIMEOUT_W'(1);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= StIdle;
      last_owner_q <= 1'b1;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      wdog_q       <= wdog_d;
    end
  end

endmodule

// File: tb/tb_checker_memory_arbiter.sv
// Directed and randomized bench for checker_memory_arbiter with a behavioural Wishbone memory.
module tb_checker_memory_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [31:0] m_adr [2];
  logic [31:0] m_wdat[2];
  logic [31:0] m_rdat[2];
  logic [3:0]  m_sel [2];
  logic        m_stb [2];
  logic        m_cyc [2];
  logic        m_we  [2];
  logic        m_ack [2];
  logic        m_err [2];
  logic [31:0] s_adr, s_dat, s_rdat;
  logic [3:0]  s_sel;
  logic        s_stb, s_cyc, s_we, s_ack;
  logic [1:0]  grant;
  logic        busy;

  // Second instance with the watchdog disabled, sharing all inputs.
  logic [31:0] d2_rdat[2];
  logic        d2_ack [2];
  logic        d2_err [2];
  logic [31:0] d2_s_adr, d2_s_dat;
  logic [3:0]  d2_s_sel;
  logic        d2_s_stb, d2_s_cyc, d2_s_we;
  logic [1:0]  d2_grant;
  logic        d2_busy;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  checker_memory_arbiter #(.TIMEOUT(8), .TIMEOUT_W(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_wdat[0]), .m0_dat_o(m_rdat[0]), .m0_sel_i(m_sel[0]),
    .m0_stb_i(m_stb[0]), .m0_cyc_i(m_cyc[0]), .m0_we_i(m_we[0]), .m0_ack_o(m_ack[0]),
    .m0_err_o(m_err[0]),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_wdat[1]), .m1_dat_o(m_rdat[1]), .m1_sel_i(m_sel[1]),
    .m1_stb_i(m_stb[1]), .m1_cyc_i(m_cyc[1]), .m1_we_i(m_we[1]), .m1_ack_o(m_ack[1]),
    .m1_err_o(m_err[1]),
    .s_adr_o(s_adr), .s_dat_o(s_dat), .s_dat_i(s_rdat), .s_sel_o(s_sel), .s_stb_o(s_stb),
    .s_cyc_o(s_cyc), .s_we_o(s_we), .s_ack_i(s_ack), .grant_o(grant), .busy_o(busy)
  );

  checker_memory_arbiter #(.TIMEOUT(0), .TIMEOUT_W(8)) dut_nowd (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_wdat[0]), .m0_dat_o(d2_rdat[0]), .m0_sel_i(m_sel[0]),
    .m0_stb_i(m_stb[0]), .m0_cyc_i(m_cyc[0]), .m0_we_i(m_we[0]), .m0_ack_o(d2_ack[0]),
    .m0_err_o(d2_err[0]),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_wdat[1]), .m1_dat_o(d2_rdat[1]), .m1_sel_i(m_sel[1]),
    .m1_stb_i(m_stb[1]), .m1_cyc_i(m_cyc[1]), .m1_we_i(m_we[1]), .m1_ack_o(d2_ack[1]),
    .m1_err_o(d2_err[1]),
    .s_adr_o(d2_s_adr), .s_dat_o(d2_s_dat), .s_dat_i(s_rdat), .s_sel_o(d2_s_sel),
    .s_stb_o(d2_s_stb), .s_cyc_o(d2_s_cyc), .s_we_o(d2_s_we), .s_ack_i(s_ack),
    .grant_o(d2_grant), .busy_o(d2_busy)
  );

  // Memory slave: acks slv_delay cycles after stb&cyc is first seen, then drops ack for a cycle.
  logic [31:0] slv_mem [256];
  logic        slv_on    = 1'b1;
  int          slv_delay = 1;
  int          slv_cnt;

  always @(posedge sys_clk) begin
    if (sys_rst) begin
      s_ack   <= 1'b0;
      slv_cnt <= 0;
      s_rdat  <= '0;
      for (int i = 0; i < 256; i++) slv_mem[i] <= '0;
    end else if (!slv_on || !(s_cyc && s_stb) || s_ack) begin
      s_ack   <= 1'b0;
      slv_cnt <= 0;
    end else if (slv_cnt + 1 >= slv_delay) begin
      s_ack   <= 1'b1;
      slv_cnt <= 0;
      s_rdat  <= slv_mem[s_adr[9:2]];
      if (s_we) begin
        for (int b = 0; b < 4; b++)
          if (s_sel[b]) slv_mem[s_adr[9:2]][8*b +: 8] <= s_dat[8*b +: 8];
      end
    end else begin
      slv_cnt <= slv_cnt + 1;
    end
  end

  logic [31:0] ref_mem [256];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive(input int m, input logic on, input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel);
    m_cyc[m]  = on;
    m_stb[m]  = on;
    m_we[m]   = we;
    m_adr[m]  = adr;
    m_wdat[m] = dat;
    m_sel[m]  = sel;
  endtask

  task automatic wait_ack(input int m, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge sys_clk);
      if (m_ack[m]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic xfer(input int m, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rdat, output logic ok);
    next_cycle();
    drive(m, 1'b1, we, adr, dat, sel);
    wait_ack(m, ok);
    rdat = m_rdat[m];
    next_cycle();
    drive(m, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    repeat (2) next_cycle();
    sys_rst = 1'b0;
  endtask

  task automatic master_run(input int m, input int n);
    logic [31:0] rdat, dat;
    logic        ok, we;
    logic [3:0]  sel;
    int          word;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) next_cycle();
      word      = m * 128 + int'($urandom_range(0, 15));
      we        = 1'($urandom_range(0, 1));
      dat       = $urandom;
      sel       = 4'($urandom_range(1, 15));
      slv_delay = int'($urandom_range(1, 3));
      xfer(m, we, 32'(word) << 2, dat, sel, rdat, ok);
      chk("rnd_ack", {63'd0, ok}, 64'd1);
      if (!we) begin
        chk("rnd_rdata", {32'd0, rdat}, {32'd0, ref_mem[word]});
      end else begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) ref_mem[word][8*b +: 8] = dat[8*b +: 8];
      end
    end
  endtask

  // Grant rules: after an idle cycle with requests, the grant comes next cycle, to the sole
  // requester or, under contention, to the master that did not own last.
  task automatic monitor(input int max_cycles, ref bit done0, ref bit done1);
    logic [1:0] prev_grant = 2'b00;
    logic [1:0] last_nz    = 2'b10;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [1:0] exp_g;
    for (int c = 0; c < max_cycles && !(done0 && done1); c++) begin
      @(negedge sys_clk);
      chk("mon_onehot", {63'd0, grant == 2'b11}, 64'd0);
      if (grant == 2'b01) chk("mon_adr0", {32'd0, s_adr}, {32'd0, m_adr[0]});
      if (grant == 2'b10) chk("mon_adr1", {32'd0, s_adr}, {32'd0, m_adr[1]});
      if (prev_grant == 2'b00 && (req0 || req1)) begin
        exp_g = (req0 && req1) ? ~last_nz : (req0 ? 2'b01 : 2'b10);
        chk("mon_grant", {62'd0, grant}, {62'd0, exp_g});
      end
      if (grant != 2'b00) last_nz = grant;
      prev_grant = grant;
      req0 = m_cyc[0];
      req1 = m_cyc[1];
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [31:0] rdat;
    logic        ok;
    int          pulses, d2_pulses;
    bit          done0, done1;

    for (int m = 0; m < 2; m++) drive(m, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) next_cycle();
    sys_rst = 1'b0;

    // Reset state
    @(negedge sys_clk);
    chk("rst_grant", {62'd0, grant}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_slave", {s_cyc, s_stb, s_we, s_adr, s_dat, s_sel}, 64'd0);
    chk("rst_ackerr", {60'd0, m_ack[0], m_ack[1], m_err[0], m_err[1]}, 64'd0);

    // 1: single master write then read back
    next_cycle();
    drive(0, 1'b1, 1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF);
    @(negedge sys_clk);
    chk("t1_lat0", {63'd0, s_cyc}, 64'd0);
    next_cycle();
    @(negedge sys_clk);
    chk("t1_scyc", {63'd0, s_cyc}, 64'd1);
    chk("t1_grant", {62'd0, grant}, 64'd1);
    chk("t1_mirror", {s_adr, s_dat}, {32'h10, 32'hA5A5_A5A5});
    wait_ack(0, ok);
    chk("t1_ack", {62'd0, ok, m_ack[1]}, 64'd2);
    next_cycle();
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge sys_clk);
    chk("t1_drop", {61'd0, s_cyc, grant}, 64'd1);
    next_cycle();
    @(negedge sys_clk);
    chk("t1_idle", {62'd0, grant}, 64'd0);
    xfer(0, 1'b0, 32'h10, '0, 4'hF, rdat, ok);
    chk("t1_read", {31'd0, ok, rdat}, {32'd1, 32'hA5A5_A5A5});

    // 2: contention alternation
    do_reset();
    drive(0, 1'b1, 1'b0, 32'h10, '0, 4'hF);
    drive(1, 1'b1, 1'b0, 32'h20, '0, 4'hF);
    next_cycle();
    @(negedge sys_clk);
    chk("t2_first", {62'd0, grant}, 64'd1);
    wait_ack(0, ok);
    next_cycle();
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge sys_clk);
    chk("t2_hold", {62'd0, grant}, 64'd1);
    next_cycle();
    @(negedge sys_clk);
    chk("t2_bubble", {62'd0, grant}, 64'd0);
    next_cycle();
    @(negedge sys_clk);
    chk("t2_second", {62'd0, grant}, 64'd2);
    wait_ack(1, ok);
    next_cycle();
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    next_cycle();
    drive(0, 1'b1, 1'b0, 32'h10, '0, 4'hF);
    drive(1, 1'b1, 1'b0, 32'h20, '0, 4'hF);
    next_cycle();
    @(negedge sys_clk);
    chk("t2_alt", {62'd0, grant}, 64'd1);
    wait_ack(0, ok);
    next_cycle();
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    wait_ack(1, ok);
    chk("t2_m1_done", {63'd0, ok}, 64'd1);
    next_cycle();
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    next_cycle();

    // 3: m1 burst of 4 writes while m0 waits
    drive(1, 1'b1, 1'b1, 32'h0, 32'h1000_0000, 4'hF);
    next_cycle();
    drive(0, 1'b1, 1'b0, 32'h4, '0, 4'hF);
    @(negedge sys_clk);
    chk("t3_grant", {62'd0, grant}, 64'd2);
    for (int k = 0; k < 4; k++) begin
      wait_ack(1, ok);
      chk("t3_m1ack", {62'd0, ok, m_ack[0]}, 64'd2);
      next_cycle();
      if (k < 3) drive(1, 1'b1, 1'b1, 32'(4 * (k + 1)), 32'h1000_0000 + 32'(k + 1), 4'hF);
      else drive(1, 1'b0, 1'b0, '0, '0, '0);
    end
    @(negedge sys_clk);
    chk("t3_hold", {61'd0, m_ack[0], grant}, 64'd2);
    next_cycle();
    @(negedge sys_clk);
    chk("t3_bubble", {62'd0, grant}, 64'd0);
    next_cycle();
    @(negedge sys_clk);
    chk("t3_m0_next", {62'd0, grant}, 64'd1);
    wait_ack(0, ok);
    chk("t3_rdata", {31'd0, ok, m_rdat[0]}, {32'd1, 32'h1000_0001});
    next_cycle();
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    next_cycle();

    // 4: watchdog with a slave that never acks
    slv_on = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h8, '0, 4'hF);
    next_cycle();
    for (int i = 0; i < 7; i++) begin
      @(negedge sys_clk);
      chk("t4_wait", {62'd0, m_err[0], s_stb}, 64'd1);
      next_cycle();
    end
    @(negedge sys_clk);
    chk("t4_err", {60'd0, m_err[0], m_err[1], s_stb, s_cyc}, 64'h8);
    next_cycle();
    @(negedge sys_clk);
    chk("t4_idle", {62'd0, grant}, 64'd0);
    next_cycle();
    @(negedge sys_clk);
    chk("t4_rearb", {62'd0, grant}, 64'd1);
    pulses = 0;
    d2_pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge sys_clk);
      if (m_err[0]) pulses++;
      if (d2_err[0] || d2_err[1]) d2_pulses++;
    end
    chk("t4_nowd_err", 64'(d2_pulses), 64'd0);
    chk("t4_wd_repeats", {63'd0, pulses > 0}, 64'd1);
    chk("t4_nowd_grant", {61'd0, d2_busy, d2_grant}, 64'd5);
    chk("t4_nowd_mirror", {d2_s_adr, 28'd0, d2_s_sel},
        {m_adr[0], 28'd0, m_sel[0]});
    chk("t4_nowd_ctl", {d2_s_dat, 26'd0, d2_s_cyc, d2_s_stb, d2_s_we, d2_ack[0], d2_ack[1],
        d2_rdat[0] == d2_rdat[1]}, {m_wdat[0], 26'd0, 6'b110001});
    next_cycle();
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    slv_on = 1'b1;
    repeat (2) next_cycle();

    // 5: ack on the last watchdog count wins
    slv_delay = 7;
    drive(0, 1'b1, 1'b0, 32'h10, '0, 4'hF);
    next_cycle();
    for (int i = 0; i < 7; i++) begin
      @(negedge sys_clk);
      chk("t5_wait", {62'd0, m_ack[0], m_err[0]}, 64'd0);
      next_cycle();
    end
    @(negedge sys_clk);
    chk("t5_tie", {60'd0, m_ack[0], m_err[0], grant}, 64'b1001);
    next_cycle();
    m_stb[0] = 1'b0;
    @(negedge sys_clk);
    chk("t5_keep", {61'd0, m_err[0], grant}, 64'd1);
    next_cycle();
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    slv_delay = 1;
    next_cycle();

    // 6: reset while OWN1 with stb high, then simultaneous request
    slv_on = 1'b0;
    drive(1, 1'b1, 1'b1, 32'h30, 32'h55, 4'hF);
    next_cycle();
    @(negedge sys_clk);
    chk("t6_own1", {62'd0, grant}, 64'd2);
    next_cycle();
    sys_rst = 1'b1;
    next_cycle();
    sys_rst = 1'b0;
    slv_on  = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h30, '0, 4'hF);
    @(negedge sys_clk);
    chk("t6_rst", {57'd0, grant, s_cyc, m_ack[0], m_ack[1], m_err[0], m_err[1]}, 64'd0);
    next_cycle();
    @(negedge sys_clk);
    chk("t6_m0_wins", {62'd0, grant}, 64'd1);
    wait_ack(0, ok);
    next_cycle();
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    wait_ack(1, ok);
    next_cycle();
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    next_cycle();

    // 6b: reset while OWN0 must also restore m0 priority
    slv_on = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h30, '0, 4'hF);
    next_cycle();
    @(negedge sys_clk);
    chk("t6b_own0", {62'd0, grant}, 64'd1);
    next_cycle();
    sys_rst = 1'b1;
    next_cycle();
    sys_rst = 1'b0;
    slv_on  = 1'b1;
    drive(1, 1'b1, 1'b0, 32'h34, '0, 4'hF);
    @(negedge sys_clk);
    chk("t6b_rst", {62'd0, grant}, 64'd0);
    next_cycle();
    @(negedge sys_clk);
    chk("t6b_m0_wins", {62'd0, grant}, 64'd1);
    wait_ack(0, ok);
    next_cycle();
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    wait_ack(1, ok);
    next_cycle();
    drive(1, 1'b0, 1'b0, '0, '0, '0);

    // Randomized traffic from both masters on disjoint halves of memory
    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    done0 = 1'b0;
    done1 = 1'b0;
    fork
      begin master_run(0, 40); done0 = 1'b1; end
      begin master_run(1, 40); done1 = 1'b1; end
      monitor(20000, done0, done1);
    join
    chk("rnd_done", {62'd0, done0, done1}, 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
